// File: rtl/down_counter_timer.sv
// Loadable down counter with terminal-count strobe, one-shot/auto-reload modes and pause/resume.
// Optional tick prescaler enabled by defining DOWN_COUNTER_TIMER_PRESCALE_EN.
module down_counter_timer #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 2) begin : g_bad_width
        $error("down_counter_timer: WIDTH must be at least 2");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("down_counter_timer: PRESCALE must be at least 2");
    end

    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_n;
    logic             tc_n;
    logic             tick_c;
    logic             go_c;

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_n;

    // A tick fires on the last cycle of each prescale period.
    assign tick_c = (presc_q == PW'(PRESCALE - 1));
`else
    assign tick_c = 1'b1;
`endif

    // stop outranks start; load outranks both and is handled first below.
    assign go_c = start & ~stop;

    // Next-state, next-count and terminal strobe.
    always_comb begin
        state_n  = state_q;
        count_n  = count;
        reload_n = reload_q;
        tc_n     = 1'b0;
`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
        presc_n  = presc_q;
`endif
        if (load) begin
            count_n  = load_val;
            reload_n = load_val;
            state_n  = IDLE;
`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
            presc_n  = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go_c && (count != CNT_ZERO)) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Pause keeps count and any partial prescale period.
                        state_n = IDLE;
                    end else begin
`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
                        presc_n = tick_c ? '0 : presc_q + PW'(1);
`endif
                        if (tick_c) begin
                            if (count > CNT_ONE) begin
                                count_n = count - CNT_ONE;
                            end else if (count == CNT_ONE) begin
                                tc_n = 1'b1;
                                if (mode) begin
                                    count_n = reload_q;
                                end else begin
                                    count_n = CNT_ZERO;
                                    state_n = DONE;
                                end
                            end else begin
                                // Zero in RUN is unreachable; park safely instead of wrapping.
                                count_n = CNT_ZERO;
                                state_n = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (go_c && (reload_q != CNT_ZERO)) begin
                        count_n = reload_q;
                        state_n = RUN;
`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
                        presc_n = '0;
`endif
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and output registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count    <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            tc       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_n;
            count    <= count_n;
            reload_q <= reload_n;
            tc       <= tc_n;
            busy     <= (state_n == RUN);
            done     <= (state_n == DONE);
        end
    end

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
    // Prescaler register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_n;
        end
    end
`endif

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed, table-driven bench for down_counter_timer with hand-written multi-cycle sequences.
module tb_down_counter_timer;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic             ld;
        logic [WIDTH-1:0] val;
        logic             st;
        logic             sp;
        logic             md;
        logic [WIDTH-1:0] c;
        logic             t;
        logic             b;
        logic             d;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic [WIDTH-1:0] v, input logic s,
                         input logic p, input logic m);
        load     = l;
        load_val = v;
        start    = s;
        stop     = p;
        mode     = m;
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] c, input logic t,
                           input logic b, input logic d);
        chk({tag, " count"}, 32'(count), 32'(c));
        chk({tag, " tc"},    32'(tc),    32'(t));
        chk({tag, " busy"},  32'(busy),  32'(b));
        chk({tag, " done"},  32'(done),  32'(d));
    endtask

    task automatic add(input logic ld, input logic [WIDTH-1:0] val, input logic st,
                       input logic sp, input logic md, input logic [WIDTH-1:0] c,
                       input logic t, input logic b, input logic d);
        vec_t v;
        v.ld = ld; v.val = val; v.st = st; v.sp = sp; v.md = md;
        v.c = c; v.t = t; v.b = b; v.d = d;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #12;
        reset = 1'b0;
        #1;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);

        // start with count == 0 is ignored
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("start0 a", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("start0 b", 4'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-count at count == 9
        drive(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (count != 4'd9 && n < 100) begin
            step();
            n++;
        end
        chk("reach9 count", 32'(count), 32'd9);
        chk("reach9 busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk_all("async reset", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk_all("post reset", 4'd0, 1'b0, 1'b0, 1'b0);

`ifndef DOWN_COUNTER_TIMER_PRESCALE_EN
        // ld val st sp md | count tc busy done
        add(1, 5, 0, 0, 0,  5, 0, 0, 0);
        add(0, 0, 1, 0, 0,  5, 0, 1, 0);
        add(0, 0, 0, 0, 0,  4, 0, 1, 0);
        add(0, 0, 0, 0, 0,  3, 0, 1, 0);
        add(0, 0, 0, 0, 0,  2, 0, 1, 0);
        add(0, 0, 0, 0, 0,  1, 0, 1, 0);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1);
        add(0, 0, 0, 0, 0,  0, 0, 0, 1);
        add(1, 3, 0, 0, 1,  3, 0, 0, 0);
        add(0, 0, 1, 0, 1,  3, 0, 1, 0);
        add(0, 0, 0, 0, 1,  2, 0, 1, 0);
        add(0, 0, 0, 0, 1,  1, 0, 1, 0);
        add(0, 0, 0, 0, 1,  3, 1, 1, 0);
        add(0, 0, 0, 0, 1,  2, 0, 1, 0);
        add(0, 0, 0, 0, 1,  1, 0, 1, 0);
        add(0, 0, 0, 0, 1,  3, 1, 1, 0);
        add(0, 0, 0, 0, 1,  2, 0, 1, 0);
        add(0, 0, 0, 0, 1,  1, 0, 1, 0);
        add(0, 0, 0, 0, 1,  3, 1, 1, 0);
        add(0, 0, 0, 0, 1,  2, 0, 1, 0);
        add(0, 0, 0, 0, 1,  1, 0, 1, 0);
        add(0, 0, 0, 0, 1,  3, 1, 1, 0);
        add(0, 0, 0, 1, 1,  3, 0, 0, 0);
        // pause / resume
        add(1, 8, 0, 0, 0,  8, 0, 0, 0);
        add(0, 0, 1, 0, 0,  8, 0, 1, 0);
        add(0, 0, 0, 0, 0,  7, 0, 1, 0);
        add(0, 0, 0, 0, 0,  6, 0, 1, 0);
        add(0, 0, 0, 0, 0,  5, 0, 1, 0);
        add(0, 0, 0, 1, 0,  5, 0, 0, 0);
        add(0, 0, 0, 0, 0,  5, 0, 0, 0);
        add(0, 0, 0, 0, 0,  5, 0, 0, 0);
        add(0, 0, 0, 0, 0,  5, 0, 0, 0);
        add(0, 0, 1, 1, 0,  5, 0, 0, 0);
        add(0, 0, 1, 0, 0,  5, 0, 1, 0);
        add(0, 0, 0, 0, 0,  4, 0, 1, 0);
        add(0, 0, 0, 0, 0,  3, 0, 1, 0);
        // DONE restart and load+start in DONE
        add(1, 1, 0, 0, 0,  1, 0, 0, 0);
        add(0, 0, 1, 0, 0,  1, 0, 1, 0);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1);
        add(0, 0, 1, 0, 0,  1, 0, 1, 0);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1);
        add(1, 6, 1, 0, 0,  6, 0, 0, 0);
        add(0, 0, 1, 0, 0,  6, 0, 1, 0);
        add(0, 0, 0, 0, 0,  5, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ld, vecs[i].val, vecs[i].st, vecs[i].sp, vecs[i].md);
            step();
            chk_all($sformatf("v%0d", i), vecs[i].c, vecs[i].t, vecs[i].b, vecs[i].d);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // maximum load value: tc after exactly 15 ticks
        drive(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("max start count", 32'(count), 32'd15);
        n = 0;
        while (!tc && n < 40) begin
            step();
            n++;
        end
        chk("max ticks", 32'(n), 32'd15);
        chk("max count", 32'(count), 32'd0);
        chk("max done", 32'(done), 32'd1);
`else
        // prescaled: load 2, one decrement every 4 cycles
        drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk_all("ps start", 4'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("ps c%0d count", i), 32'(count), (i < 4) ? 32'd2 : (i < 8) ? 32'd1 : 32'd0);
            chk($sformatf("ps c%0d tc", i), 32'(tc), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("ps done", 32'(done), 32'd1);

        // stop two cycles into a period keeps the partial period
        drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk_all("ps stop", 4'd3, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk_all("ps hold", 4'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk_all("ps resume", 4'd3, 1'b0, 1'b1, 1'b0);
        step();
        chk("ps r1 count", 32'(count), 32'd3);
        step();
        chk("ps r2 count", 32'(count), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
